// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - status/control bundle between the multicycle controller and the RV32I datapath
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zer;
    logic       neg;
    logic       pcen;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] resultsrc;
    logic [2:0] immsrc;
    logic       illegal;

    modport master (
        input  opcode, func3, func7, zer, neg,
        output pcen, adrsrc, memwrite, irwrite, regwrite,
               alusrca, alusrcb, aluop, resultsrc, immsrc, illegal
    );

    modport slave (
        output opcode, func3, func7, zer, neg,
        input  pcen, adrsrc, memwrite, irwrite, regwrite,
               alusrca, alusrcb, aluop, resultsrc, immsrc, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle RV32I datapath
module multicycle_controller #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALR2, LUI, ILLEGAL
    } state_t;

    state_t     state, next;
    logic       pcen_c, memwrite_c, irwrite_c, regwrite_c;
    logic       taken;
    logic       unused_func7;

    assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            3'b100:  alu_dec = ALU_XOR;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        case (bus.func3)
            3'b000:  taken = bus.zer;
            3'b001:  taken = !bus.zer;
            3'b100:  taken = bus.neg;
            3'b101:  taken = !bus.neg;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= next;
    end

    always_comb begin
        next          = state;
        pcen_c        = 1'b0;
        memwrite_c    = 1'b0;
        irwrite_c     = 1'b0;
        regwrite_c    = 1'b0;
        bus.adrsrc    = 1'b0;
        bus.alusrca   = 2'b00;
        bus.alusrcb   = 2'b00;
        bus.aluop     = ALU_ADD;
        bus.resultsrc = 2'b00;
        bus.immsrc    = IMM_I;
        bus.illegal   = 1'b0;
        case (state)
            FETCH: begin
                irwrite_c     = 1'b1;
                pcen_c        = 1'b1;
                bus.alusrcb   = 2'b10;
                bus.resultsrc = 2'b01;
                next          = DECODE;
            end
            DECODE: begin
                // ALUOut captures OLDPC+imm so branch/jal targets are ready later
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
                bus.immsrc  = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: next = MEMADR;
                    OP_RTYPE:          next = EXECR;
                    OP_ITYPE:          next = EXECI;
                    OP_BRANCH:         next = BRANCH;
                    OP_JAL:            next = JAL;
                    OP_JALR:           next = JALR;
                    OP_LUI:            next = LUI;
                    default:           next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                bus.immsrc  = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
                next        = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.adrsrc = 1'b1;
                next       = MEMWB;
            end
            MEMWB: begin
                bus.resultsrc = 2'b10;
                regwrite_c    = 1'b1;
                next          = FETCH;
            end
            MEMWRITE: begin
                bus.adrsrc = 1'b1;
                memwrite_c = 1'b1;
                next       = FETCH;
            end
            EXECR: begin
                bus.alusrca = 2'b10;
                bus.aluop   = alu_dec(bus.func3, bus.func7[5]);
                next        = ALUWB;
            end
            EXECI: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                bus.aluop   = alu_dec(bus.func3, 1'b0);
                next        = ALUWB;
            end
            ALUWB: begin
                regwrite_c = 1'b1;
                next       = FETCH;
            end
            BRANCH: begin
                bus.alusrca = 2'b10;
                bus.aluop   = ALU_SUB;
                pcen_c      = taken;
                next        = FETCH;
            end
            JAL: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                pcen_c      = 1'b1;
                next        = ALUWB;
            end
            JALR: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                next        = JALR2;
            end
            JALR2: begin
                // ALUOut holds rs1+imm as the new PC; ALU computes OLDPC+4 for rd
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                pcen_c      = 1'b1;
                next        = ALUWB;
            end
            LUI: begin
                bus.immsrc    = IMM_U;
                bus.resultsrc = 2'b11;
                regwrite_c    = 1'b1;
                next          = FETCH;
            end
            ILLEGAL: begin
                bus.illegal = 1'b1;
                next        = ILLEGAL_HALT ? ILLEGAL : FETCH;
            end
            default: next = FETCH;
        endcase
    end

    // Enables are masked by reset directly so nothing writes while rst is low
    assign bus.pcen     = rst & pcen_c;
    assign bus.memwrite = rst & memwrite_c;
    assign bus.irwrite  = rst & irwrite_c;
    assign bus.regwrite = rst & regwrite_c;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller, both ILLEGAL_HALT settings
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;

    multicycle_controller_if bus_h ();
    multicycle_controller_if bus_n ();

    multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(bus_h.master));
    multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n.master));

    always #5 clk = ~clk;

    logic [6:0] opcode = '0;
    logic [2:0] func3  = '0;
    logic [6:0] func7  = '0;
    logic       zer    = 1'b0;
    logic       neg    = 1'b0;

    assign bus_h.opcode = opcode;  assign bus_n.opcode = opcode;
    assign bus_h.func3  = func3;   assign bus_n.func3  = func3;
    assign bus_h.func7  = func7;   assign bus_n.func7  = func7;
    assign bus_h.zer    = zer;     assign bus_n.zer    = zer;
    assign bus_h.neg    = neg;     assign bus_n.neg    = neg;

    // {pcen,adrsrc,memwrite,irwrite,regwrite,alusrca,alusrcb,aluop,resultsrc,immsrc,illegal}
    wire [17:0] act_h = {bus_h.pcen, bus_h.adrsrc, bus_h.memwrite, bus_h.irwrite, bus_h.regwrite,
                         bus_h.alusrca, bus_h.alusrcb, bus_h.aluop, bus_h.resultsrc, bus_h.immsrc, bus_h.illegal};
    wire [17:0] act_n = {bus_n.pcen, bus_n.adrsrc, bus_n.memwrite, bus_n.irwrite, bus_n.regwrite,
                         bus_n.alusrca, bus_n.alusrcb, bus_n.aluop, bus_n.resultsrc, bus_n.immsrc, bus_n.illegal};

    function automatic logic [17:0] v(input bit p, input bit ad, input bit mw, input bit ir, input bit rw,
                                      input bit [1:0] a, input bit [1:0] b, input bit [2:0] op,
                                      input bit [1:0] rs, input bit [2:0] im, input bit il);
        v = {p, ad, mw, ir, rw, a, b, op, rs, im, il};
    endfunction

    function automatic logic [17:0] exr(input bit [2:0] op); exr = v(0,0,0,0,0, 2'd2,2'd0, op, 2'd0,3'd0,0); endfunction
    function automatic logic [17:0] exi(input bit [2:0] op); exi = v(0,0,0,0,0, 2'd2,2'd1, op, 2'd0,3'd0,0); endfunction
    function automatic logic [17:0] br(input bit t);         br  = v(t,0,0,0,0, 2'd2,2'd0, 3'd1, 2'd0,3'd0,0); endfunction

    logic [17:0] F, RSTV, DB, DJ, MADR_L, MADR_S, MREAD, MWB, MWRITE, AWB, JALV, JALRV, JALR2V, LUIV, ILL;

    typedef struct {
        logic [17:0] e_h;
        logic [17:0] e_n;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    logic [17:0] steps[$];
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (act_h !== e.e_h) begin
                errors++;
                $display("FAIL %s halt=1: got %05h expected %05h", e.nm, act_h, e.e_h);
            end
            checks++;
            if (act_n !== e.e_n) begin
                errors++;
                $display("FAIL %s halt=0: got %05h expected %05h", e.nm, act_n, e.e_n);
            end
        end
    end

    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rst = 1'b0;
            sb.push_back('{RSTV, RSTV, "reset"});
        end
    endtask

    task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input logic n);
        foreach (steps[k]) begin
            @(posedge clk); #1;
            rst = 1'b1;
            opcode = o; func3 = f3; func7 = f7; zer = z; neg = n;
            sb.push_back('{steps[k], steps[k], nm});
        end
    endtask

    initial begin
        F      = v(1,0,0,1,0, 2'd0,2'd2, 3'd0, 2'd1,3'd0,0);
        RSTV   = v(0,0,0,0,0, 2'd0,2'd2, 3'd0, 2'd1,3'd0,0);
        DB     = v(0,0,0,0,0, 2'd1,2'd1, 3'd0, 2'd0,3'd2,0);
        DJ     = v(0,0,0,0,0, 2'd1,2'd1, 3'd0, 2'd0,3'd3,0);
        MADR_L = v(0,0,0,0,0, 2'd2,2'd1, 3'd0, 2'd0,3'd0,0);
        MADR_S = v(0,0,0,0,0, 2'd2,2'd1, 3'd0, 2'd0,3'd1,0);
        MREAD  = v(0,1,0,0,0, 2'd0,2'd0, 3'd0, 2'd0,3'd0,0);
        MWB    = v(0,0,0,0,1, 2'd0,2'd0, 3'd0, 2'd2,3'd0,0);
        MWRITE = v(0,1,1,0,0, 2'd0,2'd0, 3'd0, 2'd0,3'd0,0);
        AWB    = v(0,0,0,0,1, 2'd0,2'd0, 3'd0, 2'd0,3'd0,0);
        JALV   = v(1,0,0,0,0, 2'd1,2'd2, 3'd0, 2'd0,3'd0,0);
        JALRV  = v(0,0,0,0,0, 2'd2,2'd1, 3'd0, 2'd0,3'd0,0);
        JALR2V = v(1,0,0,0,0, 2'd1,2'd2, 3'd0, 2'd0,3'd0,0);
        LUIV   = v(0,0,0,0,1, 2'd0,2'd0, 3'd0, 2'd3,3'd4,0);
        ILL    = v(0,0,0,0,0, 2'd0,2'd0, 3'd0, 2'd0,3'd0,1);

        reset_cycles(2);

        steps = '{F, DB, exr(3'd0), AWB};  run("add",   7'b0110011, 3'b000, 7'b0000000, 0, 0);
        steps = '{F, DB, exr(3'd1), AWB};  run("sub",   7'b0110011, 3'b000, 7'b0100000, 0, 0);
        steps = '{F, DB, exr(3'd2), AWB};  run("and",   7'b0110011, 3'b111, 7'b0000000, 0, 0);
        steps = '{F, DB, exr(3'd6), AWB};  run("sltu",  7'b0110011, 3'b011, 7'b0000000, 0, 0);
        steps = '{F, DB, exr(3'd0), AWB};  run("sll",   7'b0110011, 3'b001, 7'b0100000, 0, 0);
        steps = '{F, DB, exi(3'd0), AWB};  run("addi",  7'b0010011, 3'b000, 7'b0100000, 0, 0);
        steps = '{F, DB, exi(3'd4), AWB};  run("slti",  7'b0010011, 3'b010, 7'b0000000, 0, 0);
        steps = '{F, DB, exi(3'd3), AWB};  run("ori",   7'b0010011, 3'b110, 7'b0000000, 0, 0);
        steps = '{F, DB, exi(3'd5), AWB};  run("xori",  7'b0010011, 3'b100, 7'b0000000, 0, 0);

        steps = '{F, DB, MADR_L, MREAD, MWB}; run("lw", 7'b0000011, 3'b010, 7'b0000000, 0, 0);
        steps = '{F, DB, MADR_S, MWRITE};     run("sw", 7'b0100011, 3'b010, 7'b0000000, 0, 0);

        steps = '{F, DB, br(1'b1)}; run("beq_t",  7'b1100011, 3'b000, 7'b0, 1, 0);
        steps = '{F, DB, br(1'b0)}; run("beq_nt", 7'b1100011, 3'b000, 7'b0, 0, 0);
        steps = '{F, DB, br(1'b1)}; run("bne_t",  7'b1100011, 3'b001, 7'b0, 0, 0);
        steps = '{F, DB, br(1'b1)}; run("blt_t",  7'b1100011, 3'b100, 7'b0, 0, 1);
        steps = '{F, DB, br(1'b0)}; run("bge_nt", 7'b1100011, 3'b101, 7'b0, 0, 1);
        steps = '{F, DB, br(1'b0)}; run("b010",   7'b1100011, 3'b010, 7'b0, 1, 1);

        steps = '{F, DJ, JALV, AWB};          run("jal",  7'b1101111, 3'b000, 7'b0, 0, 0);
        steps = '{F, DB, JALRV, JALR2V, AWB}; run("jalr", 7'b1100111, 3'b000, 7'b0, 0, 0);
        steps = '{F, DB, LUIV};               run("lui",  7'b0110111, 3'b000, 7'b0, 0, 0);

        // Reset lands where MEMWRITE would be: memwrite must stay low
        steps = '{F, DB, MADR_S};             run("sw_cut", 7'b0100011, 3'b010, 7'b0, 0, 0);
        reset_cycles(1);
        steps = '{F, DB, MADR_L, MREAD, MWB}; run("lw_after_cut", 7'b0000011, 3'b010, 7'b0, 0, 0);

        steps = '{F, DB, ILL};                run("illegal", 7'b1111111, 3'b000, 7'b0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            sb.push_back('{ILL, (k % 3 == 0) ? F : (k % 3 == 1) ? DB : ILL, "illegal_hold"});
        end
        reset_cycles(2);
        steps = '{F, DB, exr(3'd0), AWB};     run("add_after_ill", 7'b0110011, 3'b000, 7'b0, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
